tlc_signal_head: RTL and testbench
==================================

# tlc_signal_head

Responder side of the traffic-light controller's `dir`/`ok` protocol. The master requests a direction on `dir`. This block:
- sequences the physical lamps safely through green, yellow and all-red;
- drives the 9-bit lamp vector;
- raises `ok` once the requested direction holds green and the minimum green time has elapsed, which tells the master it may issue the next request.

It is a Moore FSM with one shared down-counter, placed between the master and the lamp drivers.

## Interface
- `MIN_GRN`, 4, minimum green duration in cycles (1..256)
- `YEL_CYC`, 2, yellow duration in cycles (1..256)
- `RED_CYC`, 1, all-red clearance duration in cycles (1..256)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `dir`  in  2  requested direction: 00 NS, 01 EW, 10 left-turn (LT), 11 none (all red)
- `ok`  out  1  granted direction is green and its minimum green time has elapsed
- `grant`  out  2  direction currently holding or last holding green
- `lights`  out  9  [8:6] NS, [5:3] EW, [2:0] LT; each group is {G,Y,R}

## Operation
- States: ALLRED, GREEN, YELLOW. There is one 8-bit down-counter `tmr`, and the registered `grant` is `cur`.
- Reset (asynchronous, `rst`=0):
  - state=ALLRED, `tmr`=RED_CYC-1, `cur`=00;
  - `lights`=9'b001_001_001, `ok`=0, `grant`=00;
  - outputs take these values immediately, without waiting for a clock edge.
- Outputs are pure decodes of registered state. There is no combinational path from `dir` to any output.
  - ALLRED: all three groups 001.
  - GREEN: the `cur` group is 100, the others 001.
  - YELLOW: the `cur` group is 010, the others 001.
  - `ok` = (state==GREEN) && (`tmr`==0).
- ALLRED:
  - If `tmr`≠0: decrement.
  - If `tmr`==0 and `dir`≠11: `cur`←`dir`, state←GREEN, `tmr`←MIN_GRN-1.
  - If `tmr`==0 and `dir`==11: hold ALLRED with `tmr` at 0.
- GREEN:
  - If `tmr`≠0: decrement, regardless of `dir`.
  - If `tmr`==0 and `dir`==`cur`: hold GREEN, `ok` stays 1.
  - If `tmr`==0 and `dir`≠`cur` (11 included): state←YELLOW, `tmr`←YEL_CYC-1.
- YELLOW:
  - Runs exactly YEL_CYC cycles, then state←ALLRED, `tmr`←RED_CYC-1.
  - A change on `dir` cannot abort yellow, including a return to `cur`.
- The new direction is sampled only at ALLRED exit. Any `dir` changes during YELLOW or ALLRED count only through the value present at that edge.
- The LT group uses the same G/Y/R sequence as the other two groups. No overlap is ever allowed: at most one group is non-red at any time.
- Counter rule: load value is parameter-1. A parameter of 1 loads 0, giving a single-cycle phase.

## Timing
- After reset release with `dir` valid: RED_CYC cycles of all-red, then GREEN on the following edge.
- GREEN lasts at least MIN_GRN cycles. `ok`=0 for the first MIN_GRN-1 cycles and `ok`=1 from cycle MIN_GRN.
- Minimum request-to-request handover, measured from the first cycle `ok`=1 while `dir`≠`cur`:
  - 1 cycle of `ok`;
  - YEL_CYC yellow cycles;
  - RED_CYC all-red cycles;
  - new green on the next edge.
  - With default parameters: new green 4 cycles after the `ok` cycle.
- `ok` falls on the same edge that enters YELLOW. It is never high outside GREEN.
- `grant` changes only on the ALLRED→GREEN edge.
- Reset asserted mid-phase: all outputs return to reset values at once, and the sequence restarts from ALLRED with a full RED_CYC.

## Test plan
- **Reset then NS request.** Stimulus: hold `rst`=0, then release with `dir`=00 and default parameters. Required response:
  - during reset: `lights`=001_001_001, `ok`=0;
  - 1 all-red cycle, then `lights`=100_001_001, `grant`=00;
  - `ok`=1 from the 4th green cycle and held while `dir` stays 00.
- **NS→EW handover after `ok`.** Stimulus: switch `dir` 00→01 while `ok`=1. Required response:
  - next edge: `lights`=010_001_001 for 2 cycles;
  - then 001_001_001 for 1 cycle;
  - then 001_100_001 with `grant`=01, and `ok`=1 on the 4th EW green cycle.
- **Early request.** Stimulus: change `dir` to 10 in the 2nd NS green cycle. Required response:
  - green held for 4 cycles total, with `ok` high for exactly 1 cycle;
  - then yellow, all-red;
  - then `lights`=001_001_100, `grant`=10.
- **`dir`=11 (none).** Stimulus: set `dir`=11 during green. Required response:
  - yellow, then all-red held indefinitely with `ok`=0;
  - after setting `dir`=01, EW green appears on the next edge.
- **No abort in yellow.** Stimulus: during EW yellow, return `dir` to 01. Required response: yellow completes (2 cycles), 1 all-red cycle, then EW green again.
- **Reset mid-yellow.** Stimulus: drop `rst` mid-yellow. Required response:
  - `lights`=001_001_001 and `ok`=0 before the next clock edge;
  - after release, all-red for RED_CYC cycles, then green for the sampled `dir`.

Source files
------------

// File: rtl/tlc_signal_head.sv
// Responder-side signal head: sequences green -> yellow -> all-red per request on dir
// and raises ok once the granted direction has held green for its minimum time.
module tlc_signal_head #(
    parameter int MIN_GRN = 4,
    parameter int YEL_CYC = 2,
    parameter int RED_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dir,
    output logic       ok,
    output logic [1:0] grant,
    output logic [8:0] lights
);

    typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} state_t;

    localparam logic [7:0] GRN_LD = 8'(MIN_GRN - 1);
    localparam logic [7:0] YEL_LD = 8'(YEL_CYC - 1);
    localparam logic [7:0] RED_LD = 8'(RED_CYC - 1);
    localparam logic [1:0] NONE   = 2'b11;

    state_t     state;
    logic [7:0] tmr;
    logic [1:0] cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ALLRED;
            tmr   <= RED_LD;
            cur   <= 2'b00;
        end else begin
            case (state)
                ALLRED: begin
                    if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end else if (dir != NONE) begin
                        // the only point where a new direction is sampled
                        cur   <= dir;
                        state <= GREEN;
                        tmr   <= GRN_LD;
                    end
                end
                GREEN: begin
                    if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end else if (dir != cur) begin
                        state <= YELLOW;
                        tmr   <= YEL_LD;
                    end
                end
                YELLOW: begin
                    if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end else begin
                        state <= ALLRED;
                        tmr   <= RED_LD;
                    end
                end
                default: begin
                    state <= ALLRED;
                    tmr   <= RED_LD;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so dir never reaches the lamps directly.
    logic [2:0] grp;

    always_comb begin
        lights = 9'b001_001_001;
        grp    = (state == GREEN) ? 3'b100 : 3'b010;
        if (state == GREEN || state == YELLOW) begin
            case (cur)
                2'b00:   lights[8:6] = grp;
                2'b01:   lights[5:3] = grp;
                default: lights[2:0] = grp;
            endcase
        end
    end

    assign ok    = (state == GREEN) && (tmr == 8'd0);
    assign grant = cur;

endmodule

// File: tb/tb_tlc_signal_head.sv
// Randomized bench for tlc_signal_head: compares every cycle against a phase/elapsed-time
// model of the lamp sequence, including random mid-phase resets.
module tb_tlc_signal_head;

    localparam int MIN_GRN = 4;
    localparam int YEL_CYC = 2;
    localparam int RED_CYC = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dir;
    logic       ok;
    logic [1:0] grant;
    logic [8:0] lights;

    tlc_signal_head #(.MIN_GRN(MIN_GRN), .YEL_CYC(YEL_CYC), .RED_CYC(RED_CYC)) dut (
        .clk(clk), .rst(rst), .dir(dir), .ok(ok), .grant(grant), .lights(lights)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: which lamp phase we are in and how many cycles it has lasted so far.
    int m_phase;   // 0 all-red, 1 green, 2 yellow
    int m_elapsed;
    int m_dir;

    task automatic m_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_dir     = 0;
    endtask

    task automatic m_step(input int d);
        int done;
        done = m_elapsed + 1;  // cycles completed in this phase after this edge
        if (m_phase == 0 && done >= RED_CYC && d != 3) begin
            m_phase = 1; m_elapsed = 0; m_dir = d;
        end else if (m_phase == 1 && done >= MIN_GRN && d != m_dir) begin
            m_phase = 2; m_elapsed = 0;
        end else if (m_phase == 2 && done >= YEL_CYC) begin
            m_phase = 0; m_elapsed = 0;
        end else if (m_elapsed < 1000) begin
            m_elapsed = done;
        end
    endtask

    function automatic logic [8:0] m_lights();
        logic [2:0] g [3];
        for (int i = 0; i < 3; i++) g[i] = 3'b001;
        if (m_phase == 1) g[m_dir] = 3'b100;
        if (m_phase == 2) g[m_dir] = 3'b010;
        return {g[0], g[1], g[2]};
    endfunction

    function automatic logic m_ok();
        return (m_phase == 1) && (m_elapsed >= MIN_GRN - 1);
    endfunction

    task automatic check_all(input string where);
        chk({where, ".lights"}, 32'(lights), 32'(m_lights()));
        chk({where, ".ok"},     32'(ok),     32'(m_ok()));
        chk({where, ".grant"},  32'(grant),  32'(m_dir));
    endtask

    initial begin
        int r;
        rst = 1'b0;
        dir = 2'b00;
        m_reset();
        #1;
        check_all("reset");
        repeat (3) @(negedge clk);
        check_all("reset_hold");
        rst = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            m_step(int'(dir));
            @(negedge clk);
            check_all("run");

            // Favour holding dir so greens reach ok; change it often enough to hit early requests.
            r = int'($urandom_range(0, 9));
            if (r < 2) dir = 2'($urandom_range(0, 3));
            else if (r == 2) dir = 2'b11;

            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                m_reset();
                check_all("async_reset");
                @(negedge clk);
                check_all("reset_held");
                rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
